// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file address types and constants
package regfile_pkg;

  localparam int unsigned NREG_DFLT = 32;
  localparam int unsigned CREG_AW   = $clog2(NREG_DFLT);

  typedef logic [CREG_AW-1:0] creg_addr_t;

  localparam creg_addr_t RF_ZERO = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/issue bundle between decode and the register file
interface regfile_mp_if #(
  parameter int NREAD      = 4,
  parameter int NWRITE     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int NREG       = 32
);
  localparam int AW = $clog2(NREG);

  logic [NREAD-1:0][AW-1:0]          ra;
  logic [NREAD-1:0][DATA_WIDTH-1:0]  rd;
  logic [NREAD-1:0]                  rbusy;
  logic [NWRITE-1:0]                 we;
  logic [NWRITE-1:0][AW-1:0]         wa;
  logic [NWRITE-1:0][DATA_WIDTH-1:0] wd;
  logic [NWRITE-1:0]                 iss_en;
  logic [NWRITE-1:0][AW-1:0]         iss_addr;
  logic                              flush;

  modport master (
    output ra, we, wa, wd, iss_en, iss_addr, flush,
    input  rd, rbusy
  );

  modport slave (
    input  ra, we, wa, wd, iss_en, iss_addr, flush,
    output rd, rbusy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits; flush beats issue, issue beats write-back
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NWRITE = 2,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NWRITE-1:0]         we,
  input  logic [NWRITE-1:0][AW-1:0] wa,
  input  logic [NWRITE-1:0]         iss_en,
  input  logic [NWRITE-1:0][AW-1:0] iss_addr,
  input  logic                      flush,
  output logic [NREG-1:0]           busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && wa[j] == AW'(r)) begin
          busy_d[r] = 1'b0;
        end
      end
      // Applied after the clears so a newer producer outranks the retiring one.
      for (int k = 0; k < NWRITE; k++) begin
        if (iss_en[k] && iss_addr[k] == AW'(r)) begin
          busy_d[r] = 1'b1;
        end
      end
    end
    busy_d[int'(RF_ZERO)] = 1'b0;
    if (flush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with prioritised writes, optional bypass
// and an integrated busy scoreboard for decode stalls.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int NREAD      = 4,
  parameter int NWRITE     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int NREG       = 32,
  parameter int BYPASS     = 1
) (
  input  logic         clk,
  input  logic         resetn,
  regfile_mp_if.slave  rf
);

  localparam int AW = $clog2(NREG);

  logic [NREG-1:0]       busy;
  logic [DATA_WIDTH-1:0] mem_view [NREG];
  logic [NREAD-1:0][DATA_WIDTH-1:0] rd_c;
  logic [NREAD-1:0]                 rbusy_c;

  regfile_scoreboard #(
    .NWRITE (NWRITE),
    .NREG   (NREG),
    .AW     (AW)
  ) u_scoreboard (
    .clk      (clk),
    .resetn   (resetn),
    .we       (rf.we),
    .wa       (rf.wa),
    .iss_en   (rf.iss_en),
    .iss_addr (rf.iss_addr),
    .flush    (rf.flush),
    .busy     (busy)
  );

  assign mem_view[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic [DATA_WIDTH-1:0] val_q;
    logic [DATA_WIDTH-1:0] val_d;

    always_comb begin
      val_d = val_q;
      for (int j = 0; j < NWRITE; j++) begin
        if (rf.we[j] && rf.wa[j] == AW'(r)) begin
          val_d = rf.wd[j];
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        val_q <= '0;
      end else begin
        val_q <= val_d;
      end
    end

    assign mem_view[r] = val_q;
  end

  always_comb begin
    rd_c    = '0;
    rbusy_c = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_c[i]    = mem_view[rf.ra[i]];
      rbusy_c[i] = busy[rf.ra[i]];
      if (BYPASS != 0) begin
        // Later ports overwrite earlier matches, matching the write priority.
        for (int j = 0; j < NWRITE; j++) begin
          if (rf.we[j] && rf.wa[j] == rf.ra[i]) begin
            rd_c[i]    = rf.wd[j];
            rbusy_c[i] = 1'b0;
          end
        end
      end
      if (!resetn || rf.ra[i] == AW'(RF_ZERO)) begin
        rd_c[i]    = '0;
        rbusy_c[i] = 1'b0;
      end
    end
  end

  assign rf.rd    = rd_c;
  assign rf.rbusy = rbusy_c;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - bench for regfile_mp: directed cases on the bypass config,
// randomized traffic on two configurations against an array model.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  regfile_mp_if #(.NREAD(4), .NWRITE(2), .DATA_WIDTH(32), .NREG(32)) rfa ();
  regfile_mp_if #(.NREAD(6), .NWRITE(3), .DATA_WIDTH(64), .NREG(16)) rfb ();

  regfile_mp #(.NREAD(4), .NWRITE(2), .DATA_WIDTH(32), .NREG(32), .BYPASS(1)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .rf     (rfa)
  );

  regfile_mp #(.NREAD(6), .NWRITE(3), .DATA_WIDTH(64), .NREG(16), .BYPASS(0)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .rf     (rfb)
  );

  int n_checks = 0;
  int n_errors = 0;

  int unsigned s_ra  [2][6];
  bit          s_we  [2][3];
  int unsigned s_wa  [2][3];
  logic [63:0] s_wd  [2][3];
  bit          s_iss [2][3];
  int unsigned s_ia  [2][3];
  bit          s_flush [2];

  logic [63:0] m_reg  [2][32];
  bit          m_busy [2][32];

  function automatic int nrd(int c);  return (c == 0) ? 4 : 6;   endfunction
  function automatic int nwr(int c);  return (c == 0) ? 2 : 3;   endfunction
  function automatic int nrg(int c);  return (c == 0) ? 32 : 16; endfunction
  function automatic bit byp(int c);  return (c == 0);           endfunction
  function automatic logic [63:0] dmask(int c);
    return (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 6; i++) s_ra[c][i] = 0;
      for (int j = 0; j < 3; j++) begin
        s_we[c][j] = 0; s_wa[c][j] = 0; s_wd[c][j] = '0;
        s_iss[c][j] = 0; s_ia[c][j] = 0;
      end
      s_flush[c] = 0;
    end
  endtask

  task automatic drive_all();
    for (int i = 0; i < 4; i++) rfa.ra[i] = 5'(s_ra[0][i]);
    for (int j = 0; j < 2; j++) begin
      rfa.we[j] = s_we[0][j]; rfa.wa[j] = 5'(s_wa[0][j]); rfa.wd[j] = s_wd[0][j][31:0];
      rfa.iss_en[j] = s_iss[0][j]; rfa.iss_addr[j] = 5'(s_ia[0][j]);
    end
    rfa.flush = s_flush[0];
    for (int i = 0; i < 6; i++) rfb.ra[i] = 4'(s_ra[1][i]);
    for (int j = 0; j < 3; j++) begin
      rfb.we[j] = s_we[1][j]; rfb.wa[j] = 4'(s_wa[1][j]); rfb.wd[j] = s_wd[1][j];
      rfb.iss_en[j] = s_iss[1][j]; rfb.iss_addr[j] = 4'(s_ia[1][j]);
    end
    rfb.flush = s_flush[1];
  endtask

  task automatic apply();
    drive_all();
    #1;
  endtask

  // Model of one clock edge: last matching port wins data; flush > issue > write-back.
  task automatic update_model(int c);
    bit wr, is;
    for (int r = 0; r < 32; r++) begin
      if (!resetn) begin
        m_reg[c][r] = '0;
        m_busy[c][r] = 0;
      end else if (r != 0 && r < nrg(c)) begin
        wr = 0; is = 0;
        for (int j = 0; j < nwr(c); j++) begin
          if (s_we[c][j] && s_wa[c][j] == r) begin
            m_reg[c][r] = s_wd[c][j] & dmask(c);
            wr = 1;
          end
          if (s_iss[c][j] && s_ia[c][j] == r) is = 1;
        end
        if (s_flush[c]) m_busy[c][r] = 0;
        else if (is) m_busy[c][r] = 1;
        else if (wr) m_busy[c][r] = 0;
      end
    end
  endtask

  task automatic tick();
    update_model(0);
    update_model(1);
    @(negedge clk);
  endtask

  task automatic check_model(int c);
    logic [63:0] exp_d, got_d;
    bit exp_b, got_b;
    int unsigned a;
    for (int i = 0; i < nrd(c); i++) begin
      a = s_ra[c][i];
      exp_d = m_reg[c][a];
      exp_b = m_busy[c][a];
      if (byp(c)) begin
        for (int j = 0; j < nwr(c); j++) begin
          if (s_we[c][j] && s_wa[c][j] == a) begin
            exp_d = s_wd[c][j] & dmask(c);
            exp_b = 0;
          end
        end
      end
      if (!resetn || a == 0) begin
        exp_d = '0;
        exp_b = 0;
      end
      if (c == 0) begin
        got_d = 64'(rfa.rd[i]); got_b = rfa.rbusy[i];
      end else begin
        got_d = rfb.rd[i]; got_b = rfb.rbusy[i];
      end
      n_checks++;
      if (got_d !== exp_d) begin
        n_errors++;
        $display("FAIL rand_rd cfg%0d port%0d addr%0d: got %h expected %h", c, i, a, got_d, exp_d);
      end
      n_checks++;
      if (got_b !== exp_b) begin
        n_errors++;
        $display("FAIL rand_rbusy cfg%0d port%0d addr%0d: got %0b expected %0b", c, i, a, got_b, exp_b);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_stim();
    s_we[0][0] = 1; s_wa[0][0] = 5; s_wd[0][0] = 64'hDEAD_BEEF;
    s_iss[0][1] = 1; s_ia[0][1] = 5;
    for (int i = 0; i < 4; i++) s_ra[0][i] = 5;
    repeat (2) begin
      apply();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rfa.rd[i] !== 32'h0) begin
          n_errors++;
          $display("FAIL reset_rd port%0d: got %h expected 0", i, rfa.rd[i]);
        end
        n_checks++;
        if (rfa.rbusy[i] !== 1'b0) begin
          n_errors++;
          $display("FAIL reset_rbusy port%0d: got %0b expected 0", i, rfa.rbusy[i]);
        end
      end
      tick();
    end
    resetn = 1'b1;
    clear_stim();
    s_ra[0][0] = 5;
    apply();
    n_checks++;
    if (rfa.rd[0] !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_release_r5: got %h expected 0", rfa.rd[0]);
    end
    tick();
  endtask

  task automatic test_priority();
    clear_stim();
    s_we[0][0] = 1; s_wa[0][0] = 7; s_wd[0][0] = 64'h1111_1111;
    s_we[0][1] = 1; s_wa[0][1] = 7; s_wd[0][1] = 64'h2222_2222;
    s_ra[0][0] = 7;
    apply();
    n_checks++;
    if (rfa.rd[0] !== 32'h2222_2222) begin
      n_errors++;
      $display("FAIL prio_bypass: got %h expected 22222222", rfa.rd[0]);
    end
    tick();
    clear_stim();
    s_ra[0][0] = 7;
    apply();
    n_checks++;
    if (rfa.rd[0] !== 32'h2222_2222) begin
      n_errors++;
      $display("FAIL prio_stored: got %h expected 22222222", rfa.rd[0]);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    clear_stim();
    s_we[0][0] = 1; s_wa[0][0] = 0; s_wd[0][0] = 64'hFFFF_FFFF;
    s_iss[0][0] = 1; s_ia[0][0] = 0;
    for (int n = 0; n < 4; n++) begin
      s_ra[0][1] = 0;
      apply();
      n_checks++;
      if (rfa.rd[1] !== 32'h0 || rfa.rbusy[1] !== 1'b0) begin
        n_errors++;
        $display("FAIL zero_reg cycle%0d: got rd=%h rbusy=%0b expected rd=0 rbusy=0", n, rfa.rd[1], rfa.rbusy[1]);
      end
      tick();
      clear_stim();
    end
  endtask

  task automatic test_scoreboard();
    clear_stim();
    s_iss[0][0] = 1; s_ia[0][0] = 3; s_ra[0][0] = 3;
    apply();
    n_checks++;
    if (rfa.rbusy[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL sb_issue_same_cycle: got %0b expected 0", rfa.rbusy[0]);
    end
    tick();
    clear_stim();
    s_ra[0][0] = 3;
    apply();
    n_checks++;
    if (rfa.rbusy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL sb_issue_next_cycle: got %0b expected 1", rfa.rbusy[0]);
    end
    tick();
    clear_stim();
    s_we[0][1] = 1; s_wa[0][1] = 3; s_wd[0][1] = 64'h1234; s_ra[0][0] = 3;
    apply();
    n_checks++;
    if (rfa.rbusy[0] !== 1'b0 || rfa.rd[0] !== 32'h1234) begin
      n_errors++;
      $display("FAIL sb_writeback_bypass: got rbusy=%0b rd=%h expected rbusy=0 rd=00001234", rfa.rbusy[0], rfa.rd[0]);
    end
    tick();
    clear_stim();
    s_ra[0][0] = 3;
    apply();
    n_checks++;
    if (rfa.rbusy[0] !== 1'b0 || rfa.rd[0] !== 32'h1234) begin
      n_errors++;
      $display("FAIL sb_after_writeback: got rbusy=%0b rd=%h expected rbusy=0 rd=00001234", rfa.rbusy[0], rfa.rd[0]);
    end
    tick();
  endtask

  task automatic test_collision();
    clear_stim();
    s_iss[0][0] = 1; s_ia[0][0] = 4;
    s_iss[0][1] = 1; s_ia[0][1] = 4;
    s_we[0][1] = 1; s_wa[0][1] = 4; s_wd[0][1] = 64'hABCD;
    apply();
    tick();
    clear_stim();
    s_iss[0][0] = 1; s_ia[0][0] = 12;
    s_ra[0][0] = 4;
    apply();
    n_checks++;
    if (rfa.rd[0] !== 32'hABCD || rfa.rbusy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL collision_r4: got rd=%h rbusy=%0b expected rd=0000abcd rbusy=1", rfa.rd[0], rfa.rbusy[0]);
    end
    tick();
    clear_stim();
    s_flush[0] = 1; s_iss[0][0] = 1; s_ia[0][0] = 9;
    apply();
    tick();
    clear_stim();
    s_ra[0][0] = 9; s_ra[0][1] = 4; s_ra[0][2] = 12;
    apply();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rfa.rbusy[i] !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_port%0d addr%0d: got %0b expected 0", i, s_ra[0][i], rfa.rbusy[i]);
      end
    end
    tick();
  endtask

  task automatic test_midreset();
    clear_stim();
    s_we[0][0] = 1; s_wa[0][0] = 10; s_wd[0][0] = 64'h55AA;
    apply();
    tick();
    clear_stim();
    s_ra[0][0] = 10;
    apply();
    n_checks++;
    if (rfa.rd[0] !== 32'h55AA) begin
      n_errors++;
      $display("FAIL midreset_written: got %h expected 000055aa", rfa.rd[0]);
    end
    resetn = 1'b0;
    apply();
    tick();
    resetn = 1'b1;
    apply();
    n_checks++;
    if (rfa.rd[0] !== 32'h0) begin
      n_errors++;
      $display("FAIL midreset_cleared: got %h expected 0", rfa.rd[0]);
    end
    tick();
  endtask

  task automatic test_random(int cycles);
    for (int n = 0; n < cycles; n++) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < nrd(c); i++) s_ra[c][i] = $urandom_range(0, nrg(c) - 1);
        for (int j = 0; j < nwr(c); j++) begin
          s_we[c][j]  = ($urandom_range(0, 1) == 1);
          s_wa[c][j]  = $urandom_range(0, nrg(c) - 1);
          s_wd[c][j]  = {$urandom, $urandom};
          s_iss[c][j] = ($urandom_range(0, 2) == 0);
          s_ia[c][j]  = $urandom_range(0, nrg(c) - 1);
        end
        s_flush[c] = ($urandom_range(0, 31) == 0);
      end
      resetn = ($urandom_range(0, 499) != 0);
      apply();
      check_model(0);
      check_model(1);
      tick();
    end
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    clear_stim();
    drive_all();
    @(negedge clk);
    test_reset();
    test_priority();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_midreset();
    test_random(10000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
